// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and pure LED decode helpers for the LED pattern generator.
// Decode is written for the widest supported bank; callers truncate to their LED count.
package led_pattern_pkg;

  localparam int MODE_W    = 3;
  localparam int NUM_MODES = 5;
  localparam int MAX_LED   = 16;
  localparam int POS_MAX_W = 5;

  localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LEFT   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_RIGHT  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_FILL   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BLINK  = 3'd4;

  // LED vector shown for a given mode and position on an n-LED bank.
  function automatic logic [MAX_LED-1:0] decode_led(input logic [MODE_W-1:0]    mode,
                                                    input logic [POS_MAX_W-1:0] pos,
                                                    input int                   n);
    logic [31:0] all_on;
    logic [31:0] v;
    int          p;
    int          idx;
    p      = int'(pos);
    all_on = (32'd1 << n) - 32'd1;
    // Second half of the bounce walks back down without repeating the ends.
    idx    = (p >= n) ? (2 * n - 2 - p) : p;
    v      = '0;
    case (mode)
      MODE_BOUNCE: v = 32'd1 << idx;
      MODE_LEFT:   v = 32'd1 << p;
      MODE_RIGHT:  v = 32'd1 << (n - 1 - p);
      MODE_FILL:   v = (32'd1 << p) - 32'd1;
      MODE_BLINK:  v = (p != 0) ? all_on : 32'd0;
      default:     v = 32'd0;
    endcase
    v = v & all_on;
    return v[MAX_LED-1:0];
  endfunction

  // Last legal position of each mode's animation cycle.
  function automatic logic [POS_MAX_W-1:0] pos_last(input logic [MODE_W-1:0] mode,
                                                    input int                n);
    int last;
    case (mode)
      MODE_BOUNCE:           last = 2 * n - 3;
      MODE_LEFT, MODE_RIGHT: last = n - 1;
      MODE_FILL:             last = n;
      MODE_BLINK:            last = 1;
      default:               last = 0;
    endcase
    return POS_MAX_W'(last);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running step-rate prescaler; tick fires once per 2^(DIV_W-SPEED) clocks.
// SPEED is used live, so a change applies at the next matching count.
module led_prescaler #(
  parameter int DIV_W = 23
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] SPEED,
  output logic       tick
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] mask;

  // Each SPEED step drops one low bit from the compare, doubling the rate.
  assign mask = {DIV_W{1'b1}} >> SPEED;
  assign tick = ((div & mask) == mask);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// N-bit LED pattern generator: mode select from UP/DOWN pulses, position
// stepped by the prescaler tick, LED bank registered from decode(mode, pos).
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LED = 4,
  parameter int DIV_W = 23
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              UP,
  input  logic              DOWN,
  input  logic [1:0]        SPEED,
  input  logic              PAUSE,
  output logic [MODE_W-1:0] MODE,
  output logic [N_LED-1:0]  LED
);

  localparam int POS_W = $clog2(2 * N_LED);

  logic              tick;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic [POS_W-1:0]  pos_q;
  logic [POS_W-1:0]  pos_d;
  logic              mode_change;
  logic [N_LED-1:0]  led_d;

  led_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SPEED (SPEED),
    .tick  (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    mode_d      = mode_q;
    pos_d       = pos_q;
    mode_change = 1'b0;

    // An out-of-range mode is treated as a change back to BOUNCE.
    if (mode_q > MODE_BLINK) begin
      mode_d      = MODE_BOUNCE;
      mode_change = 1'b1;
    end else if (UP && !DOWN) begin
      mode_d      = (mode_q == MODE_BLINK) ? MODE_BOUNCE : mode_q + 3'd1;
      mode_change = 1'b1;
    end else if (DOWN && !UP) begin
      mode_d      = (mode_q == MODE_BOUNCE) ? MODE_BLINK : mode_q - 3'd1;
      mode_change = 1'b1;
    end

    // A mode change restarts the animation and outranks a coincident tick.
    if (mode_change) begin
      pos_d = '0;
    end else if (tick && !PAUSE) begin
      pos_d = (pos_q == POS_W'(pos_last(mode_q, N_LED))) ? '0 : pos_q + 1'b1;
    end
  end

  assign led_d = N_LED'(decode_led(mode_q, POS_MAX_W'(pos_q), N_LED));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= MODE_BOUNCE;
      pos_q  <= '0;
      LED    <= '0;
    end else begin
      mode_q <= mode_d;
      pos_q  <= pos_d;
      LED    <= led_d;
    end
  end

  assign MODE = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench: 4-LED and 8-LED generators (DIV_W=4) on shared inputs,
// compared against a sequence-level model of the animation rules.
module tb_led_pattern_gen;

  localparam int DIV_W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up;
  logic       down;
  logic [1:0] speed;
  logic       pause;
  logic [2:0] mode4;
  logic [2:0] mode8;
  logic [3:0] led4;
  logic [7:0] led8;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: one mode shared by both banks, per-bank position and LED.
  int          m_mode;
  int          m_div;
  int          m_pos[2];
  logic [15:0] m_led[2];
  int          nled[2] = '{4, 8};

  always #5 clk = ~clk;

  led_pattern_gen #(.N_LED(4), .DIV_W(DIV_W)) dut4 (
    .CLK(clk), .RST_N(rst_n), .UP(up), .DOWN(down), .SPEED(speed),
    .PAUSE(pause), .MODE(mode4), .LED(led4)
  );

  led_pattern_gen #(.N_LED(8), .DIV_W(DIV_W)) dut8 (
    .CLK(clk), .RST_N(rst_n), .UP(up), .DOWN(down), .SPEED(speed),
    .PAUSE(pause), .MODE(mode8), .LED(led8)
  );

  function automatic logic [15:0] dut_led(input int d);
    return (d == 0) ? {12'b0, led4} : {8'b0, led8};
  endfunction

  function automatic logic [2:0] dut_mode(input int d);
    return (d == 0) ? mode4 : mode8;
  endfunction

  // Number of distinct frames in each animation.
  function automatic int seq_len(input int mode, input int n);
    case (mode)
      0:       return 2 * n - 2;
      1, 2:    return n;
      3:       return n + 1;
      default: return 2;
    endcase
  endfunction

  // Frame k of each animation, described as the pattern a viewer sees.
  function automatic logic [15:0] pattern(input int mode, input int k, input int n);
    int          walk[$];
    logic [15:0] one;
    logic [15:0] all;
    one = 16'd1;
    all = (one << n) - one;
    case (mode)
      0: begin
        for (int i = 0; i < n; i++) walk.push_back(i);
        for (int i = n - 2; i >= 1; i--) walk.push_back(i);
        return one << walk[k];
      end
      1:       return one << k;
      2:       return one << (n - 1 - k);
      3:       return (one << k) - one;
      default: return (k % 2 == 1) ? all : 16'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_div  = 0;
    for (int d = 0; d < 2; d++) begin
      m_pos[d] = 0;
      m_led[d] = '0;
    end
  endtask

  task automatic model_edge(input logic u, input logic dn);
    int period;
    bit tk;
    period = (1 << DIV_W) >> speed;
    tk     = ((m_div % period) == period - 1);
    for (int d = 0; d < 2; d++) m_led[d] = pattern(m_mode, m_pos[d], nled[d]);
    if (u != dn) begin
      m_mode = u ? (m_mode + 1) % 5 : (m_mode + 4) % 5;
      for (int d = 0; d < 2; d++) m_pos[d] = 0;
    end else if (tk && !pause) begin
      for (int d = 0; d < 2; d++) m_pos[d] = (m_pos[d] + 1) % seq_len(m_mode, nled[d]);
    end
    m_div = (m_div + 1) % (1 << DIV_W);
  endtask

  // One clock: inputs held across the rising edge, then released at the falling edge.
  task automatic step(input logic u, input logic dn);
    up   = u;
    down = dn;
    @(posedge clk);
    model_edge(u, dn);
    @(negedge clk);
    up   = 1'b0;
    down = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    up    = 1'b0;
    down  = 1'b0;
    pause = 1'b0;
    speed = 2'd0;
    #3;
    n_checks++;
    if (led4 !== 4'b0000 || led8 !== 8'h00 || mode4 !== 3'd0 || mode8 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: led4=%b led8=%b mode4=%0d mode8=%0d, expected all zero",
               led4, led8, mode4, mode8);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    n_checks++;
    if (led4 !== 4'b0001 || led8 !== 8'h01 || mode4 !== 3'd0) begin
      n_fail++;
      $display("FAIL first_edge: led4=%b led8=%b mode4=%0d, expected 0001 00000001 0",
               led4, led8, mode4);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] table4[7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 1; i <= 6; i++) begin
      for (int c = 0; c < 16; c++) begin
        step(1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if (dut_led(d) !== m_led[d] || dut_mode(d) !== 3'(m_mode)) begin
            n_fail++;
            $display("FAIL bounce_cycle: dut%0d led=%h mode=%0d, expected led=%h mode=%0d",
                     d, dut_led(d), dut_mode(d), m_led[d], m_mode);
          end
        end
      end
      n_checks++;
      if (led4 !== table4[i] || mode4 !== 3'd0) begin
        n_fail++;
        $display("FAIL bounce_frame%0d: led4=%b mode4=%0d, expected %b 0", i, led4, mode4, table4[i]);
      end
    end
  endtask

  task automatic test_modes();
    int next_mode[4] = '{2, 3, 4, 0};
    step(1'b1, 1'b0);
    n_checks++;
    if (mode4 !== 3'd1 || mode8 !== 3'd1) begin
      n_fail++;
      $display("FAIL up_pulse: mode4=%0d mode8=%0d, expected 1", mode4, mode8);
    end
    for (int c = 0; c < 80; c++) begin
      step(1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (dut_led(d) !== m_led[d] || dut_mode(d) !== 3'(m_mode)) begin
          n_fail++;
          $display("FAIL left_cycle: dut%0d led=%h mode=%0d, expected led=%h mode=%0d",
                   d, dut_led(d), dut_mode(d), m_led[d], m_mode);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      n_checks++;
      if (mode4 !== 3'(next_mode[i]) || led4 !== m_led[0]) begin
        n_fail++;
        $display("FAIL up_wrap%0d: mode4=%0d led4=%b, expected mode %0d led %b",
                 i, mode4, led4, next_mode[i], m_led[0][3:0]);
      end
    end
    step(1'b0, 1'b1);
    n_checks++;
    if (mode4 !== 3'd4 || mode8 !== 3'd4) begin
      n_fail++;
      $display("FAIL down_wrap: mode4=%0d mode8=%0d, expected 4", mode4, mode8);
    end
    for (int c = 0; c < 48; c++) begin
      step(1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (dut_led(d) !== m_led[d] || dut_mode(d) !== 3'(m_mode)) begin
          n_fail++;
          $display("FAIL blink_cycle: dut%0d led=%h mode=%0d, expected led=%h mode=%0d",
                   d, dut_led(d), dut_mode(d), m_led[d], m_mode);
        end
      end
    end
  endtask

  task automatic test_coincident();
    int guard;
    step(1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (mode4 !== 3'd4 || led4 !== m_led[0] || led8 !== m_led[1][7:0]) begin
        n_fail++;
        $display("FAIL up_down_same: mode4=%0d led4=%b led8=%b, expected mode 4 led4 %b led8 %b",
                 mode4, led4, led8, m_led[0][3:0], m_led[1][7:0]);
      end
      step(1'b0, 1'b0);
    end
    guard = 0;
    while (m_div != (1 << DIV_W) - 1 && guard < 32) begin
      step(1'b0, 1'b0);
      guard++;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    n_checks++;
    if (mode4 !== 3'd0 || led4 !== 4'b0001 || led8 !== 8'h01) begin
      n_fail++;
      $display("FAIL up_with_tick: mode4=%0d led4=%b led8=%b, expected 0 0001 00000001",
               mode4, led4, led8);
    end
  endtask

  task automatic test_fill_speed();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    speed = 2'd3;
    for (int c = 0; c < 44; c++) begin
      step(1'b0, 1'b0);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (dut_led(d) !== m_led[d] || dut_mode(d) !== 3'd3) begin
          n_fail++;
          $display("FAIL fill_fast: dut%0d led=%h mode=%0d, expected led=%h mode=3",
                   d, dut_led(d), dut_mode(d), m_led[d]);
        end
      end
    end
    speed = 2'd0;
  endtask

  task automatic test_pause();
    int guard;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    guard = 0;
    while (led4 !== 4'b0100 && guard < 200) begin
      step(1'b0, 1'b0);
      guard++;
    end
    n_checks++;
    if (led4 !== 4'b0100 || mode4 !== 3'd1) begin
      n_fail++;
      $display("FAIL pause_setup: led4=%b mode4=%0d, expected 0100 1", led4, mode4);
    end
    pause = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (led4 !== 4'b0100 || led8 !== m_led[1][7:0]) begin
        n_fail++;
        $display("FAIL pause_hold: led4=%b led8=%b, expected 0100 %b", led4, led8, m_led[1][7:0]);
      end
    end
    pause = 1'b0;
    guard = 0;
    while (led4 === 4'b0100 && guard < 40) begin
      step(1'b0, 1'b0);
      guard++;
    end
    n_checks++;
    if (led4 !== 4'b1000) begin
      n_fail++;
      $display("FAIL pause_release: led4=%b, expected 1000", led4);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    step(1'b1, 1'b0);
    guard = 0;
    while (m_pos[0] != 2 && guard < 100) begin
      step(1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 1'b0);
    n_checks++;
    if (mode4 !== 3'd2 || led4 !== 4'b0010) begin
      n_fail++;
      $display("FAIL right_pos2: mode4=%0d led4=%b, expected 2 0010", mode4, led4);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (led4 !== 4'b0000 || led8 !== 8'h00 || mode4 !== 3'd0 || mode8 !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: led4=%b led8=%b mode4=%0d mode8=%0d, expected all zero",
               led4, led8, mode4, mode8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    n_checks++;
    if (led4 !== 4'b0001 || mode4 !== 3'd0) begin
      n_fail++;
      $display("FAIL restart_bounce: led4=%b mode4=%0d, expected 0001 0", led4, mode4);
    end
  endtask

  task automatic test_random();
    int  r;
    bit  u;
    bit  dn;
    for (int c = 0; c < 3000; c++) begin
      r  = int'($urandom_range(0, 99));
      u  = (r < 3) || (r == 6);
      dn = (r >= 3 && r < 7);
      if ($urandom_range(0, 49) == 0) pause = ~pause;
      if ($urandom_range(0, 99) == 0) speed = 2'($urandom_range(0, 3));
      step(u, dn);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (dut_led(d) !== m_led[d] || dut_mode(d) !== 3'(m_mode)) begin
          n_fail++;
          $display("FAIL random_cycle%0d: dut%0d led=%h mode=%0d, expected led=%h mode=%0d",
                   c, d, dut_led(d), dut_mode(d), m_led[d], m_mode);
        end
      end
    end
    pause = 1'b0;
    speed = 2'd0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_modes();
    test_coincident();
    test_fill_speed();
    test_pause();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator: drives an N-bit LED bank with one of five animated patterns, stepped by an internal, programmable-rate prescaler. It sits between the two debounced push-button pulses (mode up/down) and the board LED pins. It generalises the fixed 4-LED, three-pattern chaser with a configurable LED count, speed selection, pause, clean mode wrap-around and a readable mode output.

## Interface
- N_LED, 4: number of LEDs; legal range 2..16.
- DIV_W, 23: prescaler width; base step period is 2^DIV_W clocks; must be ≥ 4.
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- UP  in  1  single-cycle pulse from the debouncer; advance the mode.
- DOWN  in  1  single-cycle pulse from the debouncer; retreat the mode.
- SPEED  in  2  step rate; period = 2^(DIV_W − SPEED) clocks.
- PAUSE  in  1  level; freezes the animation while high.
- MODE  out  3  current mode, registered.
- LED  out  N_LED  LED drive, registered, active-high.

## Operation
- Modes:
  - 0 BOUNCE: single lit LED, ping-pong.
  - 1 LEFT: single LED rotating LSB→MSB.
  - 2 RIGHT: single LED rotating MSB→LSB.
  - 3 FILL: bar graph of 0..N_LED LEDs lit from the LSB.
  - 4 BLINK: all LEDs on/off alternately.
- Mode select:
  - UP alone: mode+1; 4 wraps to 0.
  - DOWN alone: mode−1; 0 wraps to 4.
  - UP and DOWN in the same cycle: ignored.
- Any mode change sets the position counter `pos` to 0 in the same edge.
- Prescaler: free-running DIV_W-bit counter `div`.
  - `tick` = (div[DIV_W−1−SPEED:0] all ones).
  - SPEED is sampled live; a change takes effect at the next matching count.
- Position update on `tick`, when PAUSE is low and there is no mode change:
  - BOUNCE: pos 0..2N−3, then wraps to 0.
  - LEFT/RIGHT: pos 0..N−1, then wraps.
  - FILL: pos 0..N, then wraps.
  - BLINK: pos 0..1, then wraps.
- A mode change wins over a tick in the same cycle.
- `pos` width is clog2(2·N_LED).
- Decode (idx = pos, or 2N−2−pos when pos ≥ N):
  - BOUNCE: LED = onehot(idx).
  - LEFT: LED = onehot(pos).
  - RIGHT: LED = onehot(N−1−pos).
  - FILL: LED = (1<<pos)−1.
  - BLINK: LED = pos ? all-ones : 0.
- LED register loads decode(mode, pos) every cycle. PAUSE holds the lit pattern, not blank.
- An illegal internal mode value (5..7) decodes to 0 and is forced back to 0 on the next edge.

## Timing
- Reset (RST_N low, asynchronous): MODE=0, pos=0, div=0, LED=0.
- First edge after release: LED = onehot(0) (BOUNCE, pos 0).
- Latency:
  - tick/mode edge → pos updated at that edge.
  - LED reflects the new pos/mode one clock later.
  - MODE output changes at the same edge as the internal mode.
- Reset asserted mid-animation clears all state immediately, independent of CLK.
- Pulses on UP/DOWN must be one cycle wide. A held level advances the mode every cycle, by design.

## Structure
- Package `led_pattern_pkg`:
  - mode constants MODE_BOUNCE=0, MODE_LEFT=1, MODE_RIGHT=2, MODE_FILL=3, MODE_BLINK=4.
  - NUM_MODES=5 and MODE_W=3.
  - a pure decode function (mode, pos, N) → LED vector.
- Sub-module `led_prescaler`:
  - parameter DIV_W.
  - ports CLK, RST_N, SPEED, tick.
  - owns the `div` counter and the tick compare.
- The top holds the mode register, the `pos` counter and the LED register. It is instantiated alongside two existing `debounce` instances.

## Test plan
- N_LED=4, DIV_W=4, SPEED=0; release reset: LED sequence per 16-clock tick is 0001,0010,0100,1000,0100,0010,0001; MODE=0.
- One UP pulse, then 4 ticks: MODE=1, LED 0001,0010,0100,1000,0001. Four more UP pulses: MODE 2,3,4,0. DOWN at MODE=0 gives MODE=4, BLINK toggles 0000/1111 per tick.
- UP and DOWN in the same cycle: MODE unchanged, pos unchanged. UP coincident with tick: pos=0 after the edge and LED=onehot(0) in the new mode.
- FILL, N_LED=8: LED 00000000, 00000001, 00000011 … 11111111, then 00000000 (9-step period). SPEED=3 gives a 2-clock tick period at DIV_W=4.
- PAUSE high for 50 clocks in LEFT at LED=0100: LED stays 0100. Release: the next tick gives 1000.
- RST_N pulsed low mid-cycle in RIGHT at pos 2: LED=0, MODE=0 immediately without a clock edge. After release, BOUNCE restarts at 0001.
